// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared types, default parameters and arbitration helper
//               for the two-port memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_ADRBITS = 8;
    localparam int DEF_WAIT    = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // last = 1 means port 1 was served most recently, so port 0 wins a tie.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
        logic [1:0] grant;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        return grant;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester round-robin arbiter with one-hot grant and
//               last-grant register.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import mem_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] grant_o,
    output logic       last_o
);

    logic last_q;

    assign grant_o = rr_pick(req_i, last_q);
    assign last_o  = last_q;

    // Reset value 1 makes port 0 the first winner.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= 1'b1;
        end else if (en_i && (req_i != 2'b00)) begin
            last_q <= grant_o[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl
// Description : Two-port (fetch/data) round-robin memory controller with
//               configurable wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ADRBITS = DEF_ADRBITS,
    parameter int WAIT    = DEF_WAIT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               p0_req,
    input  logic               p0_we,
    input  logic [ADRBITS-1:0] p0_adr,
    input  logic [WIDTH-1:0]   p0_wdata,
    output logic [WIDTH-1:0]   p0_rdata,
    output logic               p0_ack,
    input  logic               p1_req,
    input  logic               p1_we,
    input  logic [ADRBITS-1:0] p1_adr,
    input  logic [WIDTH-1:0]   p1_wdata,
    output logic [WIDTH-1:0]   p1_rdata,
    output logic               p1_ack,
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADRBITS-1:0] mem_adr,
    output logic [WIDTH-1:0]   mem_wdata,
    input  logic [WIDTH-1:0]   mem_rdata,
    output logic               busy
);

    localparam logic [2:0] WAIT_CNT = 3'(WAIT);

    state_t               state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic                 we_q, we_d;
    logic [ADRBITS-1:0]   adr_q, adr_d;
    logic [WIDTH-1:0]     wdata_q, wdata_d;
    logic [WIDTH-1:0]     rdata0_q, rdata0_d;
    logic [WIDTH-1:0]     rdata1_q, rdata1_d;
    logic [1:0]           grant;
    logic                 last_grant;
    logic                 arb_en;

    assign arb_en = (state_q == IDLE);

    // The arbiter's last-grant register updates on the same edge the
    // request is latched, so it identifies the port being served.
    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req_i   ({p1_req, p0_req}),
        .en_i    (arb_en),
        .grant_o (grant),
        .last_o  (last_grant)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        adr_d    = adr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        p0_ack   = 1'b0;
        p1_ack   = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant[1]) begin
                    we_d    = p1_we;
                    adr_d   = p1_adr;
                    wdata_d = p1_wdata;
                    cnt_d   = 3'd0;
                    state_d = ACCESS;
                end else if (grant[0]) begin
                    we_d    = p0_we;
                    adr_d   = p0_adr;
                    wdata_d = p0_wdata;
                    cnt_d   = 3'd0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                mem_en = (cnt_q == 3'd0);
                mem_we = (cnt_q == 3'd0) && we_q;
                if (cnt_q == WAIT_CNT) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            RESP: begin
                if (last_grant) begin
                    p1_ack = 1'b1;
                    if (!we_q) rdata1_d = mem_rdata;
                end else begin
                    p0_ack = 1'b1;
                    if (!we_q) rdata0_d = mem_rdata;
                end
                cnt_d   = 3'd0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign mem_adr   = adr_q;
    assign mem_wdata = wdata_q;
    assign p0_rdata  = rdata0_q;
    assign p1_rdata  = rdata1_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_ctrl
// Description : Self-checking bench for mem_ctrl (WAIT=2 main instance,
//               WAIT=0 secondary instance) against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

    localparam int WAIT_TB = 2;
    localparam int LAT     = 2 + WAIT_TB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       p0_req, p0_we, p1_req, p1_we;
    logic [7:0] p0_adr, p0_wdata, p1_adr, p1_wdata;
    logic [7:0] p0_rdata, p1_rdata;
    logic       p0_ack, p1_ack;
    logic       mem_en, mem_we, busy;
    logic [7:0] mem_adr, mem_wdata, mem_rdata;

    logic       z_req, z_zero1;
    logic [7:0] z_adr, z_zero8;
    logic [7:0] z_p0_rdata, z_p1_rdata, z_mem_adr, z_mem_wdata, z_mem_rdata;
    logic       z_p0_ack, z_p1_ack, z_mem_en, z_mem_we, z_busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] ref_mem [256];
    logic [7:0] exp_rd  [2];

    mem_ctrl #(.WIDTH(8), .ADRBITS(8), .WAIT(WAIT_TB)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_adr(p0_adr), .p0_wdata(p0_wdata),
        .p0_rdata(p0_rdata), .p0_ack(p0_ack),
        .p1_req(p1_req), .p1_we(p1_we), .p1_adr(p1_adr), .p1_wdata(p1_wdata),
        .p1_rdata(p1_rdata), .p1_ack(p1_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_ctrl #(.WIDTH(8), .ADRBITS(8), .WAIT(0)) dut0 (
        .clk(clk), .reset(reset),
        .p0_req(z_req), .p0_we(z_zero1), .p0_adr(z_adr), .p0_wdata(z_zero8),
        .p0_rdata(z_p0_rdata), .p0_ack(z_p0_ack),
        .p1_req(z_zero1), .p1_we(z_zero1), .p1_adr(z_zero8), .p1_wdata(z_zero8),
        .p1_rdata(z_p1_rdata), .p1_ack(z_p1_ack),
        .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_adr(z_mem_adr), .mem_wdata(z_mem_wdata),
        .mem_rdata(z_mem_rdata), .busy(z_busy)
    );

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return (a == 8'h10) ? 8'h5A : 8'(a * 8'd37 + 8'd11);
    endfunction

    // Synchronous RAM: read data appears the cycle after mem_en and holds.
    logic [7:0] mem [256];
    logic       mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
            mem_loaded <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) mem[mem_adr] <= mem_wdata;
            else        mem_rdata    <= mem[mem_adr];
        end
    end

    always @(posedge clk) begin
        if (z_mem_en) z_mem_rdata <= init_val(z_mem_adr);
    end

    // Drives one request (caller is at a negedge, controller idle), measures it,
    // and returns both rdata outputs one cycle after the ack.
    task automatic run_access(input int port, input logic we, input logic [7:0] adr,
                              input logic [7:0] wd, input logic drop_early,
                              output int lat, output int en_cnt, output int we_cnt,
                              output logic [7:0] s_adr, output logic [7:0] s_wd,
                              output int other_ack, output logic [7:0] rd0,
                              output logic [7:0] rd1);
        lat = 0; en_cnt = 0; we_cnt = 0; other_ack = 0; s_adr = '0; s_wd = '0;
        if (port == 0) begin
            p0_req = 1'b1; p0_we = we; p0_adr = adr; p0_wdata = wd;
        end else begin
            p1_req = 1'b1; p1_we = we; p1_adr = adr; p1_wdata = wd;
        end
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (mem_en) begin en_cnt++; s_adr = mem_adr; s_wd = mem_wdata; end
            if (mem_we) we_cnt++;
            if ((port == 0) ? p1_ack : p0_ack) other_ack++;
            if (drop_early && c == 1) begin
                if (port == 0) p0_req = 1'b0; else p1_req = 1'b0;
            end
            if ((port == 0) ? p0_ack : p1_ack) begin lat = c; break; end
        end
        if (port == 0) p0_req = 1'b0; else p1_req = 1'b0;
        @(negedge clk);
        rd0 = p0_rdata;
        rd1 = p1_rdata;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({p0_rdata, p1_rdata, p0_ack, p1_ack, mem_en, mem_we, mem_adr, mem_wdata, busy} !== 38'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h required 0",
                     {p0_rdata, p1_rdata, p0_ack, p1_ack, mem_en, mem_we, mem_adr, mem_wdata, busy});
        end
        checks++;
        if ({z_p0_rdata, z_p0_ack, z_mem_en, z_busy, z_mem_adr} !== 19'd0) begin
            failures++;
            $display("FAIL reset_outputs_w0: got %h required 0",
                     {z_p0_rdata, z_p0_ack, z_mem_en, z_busy, z_mem_adr});
        end
        reset = 1'b1;
    endtask

    task automatic test_contention();
        logic [7:0] a0, a1;
        int order[$];
        int last = -1;
        int dbl = 0;
        a0 = 8'($urandom); a1 = 8'($urandom);
        p0_req = 1'b1; p0_we = 1'b0; p0_adr = a0;
        p1_req = 1'b1; p1_we = 1'b0; p1_adr = a1;
        for (int c = 0; c < 80 && order.size() < 4; c++) begin
            @(negedge clk);
            if (last >= 0) begin
                checks++;
                if (((last == 0) ? p0_rdata : p1_rdata) !== ref_mem[(last == 0) ? a0 : a1]) begin
                    failures++;
                    $display("FAIL contention_rdata p%0d: got %h required %h", last,
                             (last == 0) ? p0_rdata : p1_rdata, ref_mem[(last == 0) ? a0 : a1]);
                end
                last = -1;
            end
            if (p0_ack && p1_ack) dbl++;
            if (p0_ack)      begin order.push_back(0); last = 0; end
            else if (p1_ack) begin order.push_back(1); last = 1; end
        end
        p0_req = 1'b0; p1_req = 1'b0;
        @(negedge clk);
        checks++;
        if (p1_rdata !== ref_mem[a1]) begin
            failures++;
            $display("FAIL contention_last_rdata: got %h required %h", p1_rdata, ref_mem[a1]);
        end
        checks++;
        if (order.size() != 4) begin
            failures++;
            $display("FAIL contention_count: got %0d acks required 4", order.size());
        end
        for (int i = 0; i < order.size(); i++) begin
            checks++;
            if (order[i] != (i % 2)) begin
                failures++;
                $display("FAIL contention_order[%0d]: got p%0d required p%0d", i, order[i], i % 2);
            end
        end
        checks++;
        if (dbl != 0) begin
            failures++;
            $display("FAIL contention_double_ack: got %0d required 0", dbl);
        end
        exp_rd[0] = ref_mem[a0];
        exp_rd[1] = ref_mem[a1];
    endtask

    task automatic test_read();
        int lat, en_cnt, we_cnt, oth;
        logic [7:0] sa, sw, r0, r1;
        run_access(0, 1'b0, 8'h10, 8'h00, 1'b0, lat, en_cnt, we_cnt, sa, sw, oth, r0, r1);
        exp_rd[0] = ref_mem[8'h10];
        checks++;
        if (lat != LAT) begin failures++; $display("FAIL read_latency: got %0d required %0d", lat, LAT); end
        checks++;
        if (en_cnt != 1 || we_cnt != 0) begin
            failures++; $display("FAIL read_strobes: got en=%0d we=%0d required en=1 we=0", en_cnt, we_cnt);
        end
        checks++;
        if (sa !== 8'h10) begin failures++; $display("FAIL read_adr: got %h required 10", sa); end
        checks++;
        if (r0 !== 8'h5A) begin failures++; $display("FAIL read_data: got %h required 5a", r0); end
    endtask

    task automatic test_write();
        int lat, en_cnt, we_cnt, oth;
        logic [7:0] sa, sw, r0, r1;
        run_access(1, 1'b1, 8'h20, 8'hC3, 1'b0, lat, en_cnt, we_cnt, sa, sw, oth, r0, r1);
        ref_mem[8'h20] = 8'hC3;
        checks++;
        if (lat != LAT) begin failures++; $display("FAIL write_latency: got %0d required %0d", lat, LAT); end
        checks++;
        if (we_cnt != 1 || en_cnt != 1) begin
            failures++; $display("FAIL write_strobes: got en=%0d we=%0d required 1/1", en_cnt, we_cnt);
        end
        checks++;
        if (sa !== 8'h20 || sw !== 8'hC3) begin
            failures++; $display("FAIL write_bus: got adr=%h data=%h required 20/c3", sa, sw);
        end
        checks++;
        if (r1 !== exp_rd[1]) begin failures++; $display("FAIL write_keeps_rdata: got %h required %h", r1, exp_rd[1]); end
        run_access(1, 1'b0, 8'h20, 8'h00, 1'b0, lat, en_cnt, we_cnt, sa, sw, oth, r0, r1);
        exp_rd[1] = ref_mem[8'h20];
        checks++;
        if (r1 !== 8'hC3) begin failures++; $display("FAIL write_readback: got %h required c3", r1); end
    endtask

    task automatic test_early_drop();
        int lat, en_cnt, we_cnt, oth, extra;
        logic [7:0] a, sa, sw, r0, r1;
        a = 8'($urandom);
        run_access(1, 1'b0, a, 8'h00, 1'b1, lat, en_cnt, we_cnt, sa, sw, oth, r0, r1);
        exp_rd[1] = ref_mem[a];
        extra = 0;
        repeat (6) begin @(negedge clk); if (p1_ack || p0_ack) extra++; end
        checks++;
        if (lat != LAT) begin failures++; $display("FAIL early_drop_latency: got %0d required %0d", lat, LAT); end
        checks++;
        if (extra != 0 || oth != 0) begin
            failures++; $display("FAIL early_drop_single_ack: got extra=%0d other=%0d required 0/0", extra, oth);
        end
        checks++;
        if (r1 !== exp_rd[1]) begin failures++; $display("FAIL early_drop_data: got %h required %h", r1, exp_rd[1]); end
    endtask

    task automatic test_random();
        int lat, en_cnt, we_cnt, oth, port;
        logic we;
        logic [7:0] a, d, sa, sw, r0, r1;
        for (int n = 0; n < 20; n++) begin
            port = int'($urandom_range(1, 0));
            we   = 1'($urandom);
            a    = 8'($urandom);
            d    = 8'($urandom);
            run_access(port, we, a, d, 1'b0, lat, en_cnt, we_cnt, sa, sw, oth, r0, r1);
            if (we) ref_mem[a] = d;
            else    exp_rd[port] = ref_mem[a];
            checks++;
            if (lat != LAT || en_cnt != 1 || we_cnt != int'(we) || oth != 0) begin
                failures++;
                $display("FAIL rand_timing #%0d: got lat=%0d en=%0d we=%0d oth=%0d required %0d/1/%0d/0",
                         n, lat, en_cnt, we_cnt, oth, LAT, we);
            end
            checks++;
            if (sa !== a || (we && sw !== d)) begin
                failures++; $display("FAIL rand_bus #%0d: got adr=%h data=%h required %h/%h", n, sa, sw, a, d);
            end
            checks++;
            if (r0 !== exp_rd[0] || r1 !== exp_rd[1]) begin
                failures++;
                $display("FAIL rand_rdata #%0d: got %h/%h required %h/%h", n, r0, r1, exp_rd[0], exp_rd[1]);
            end
        end
    endtask

    task automatic test_abort();
        int lat, en_cnt, we_cnt, oth, bad;
        logic [7:0] a, sa, sw, r0, r1;
        a = 8'($urandom);
        p0_req = 1'b1; p0_we = 1'b0; p0_adr = a;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy_before: got %b required 1", busy); end
        reset = 1'b0;
        #1;
        checks++;
        if ({p0_rdata, p1_rdata, p0_ack, p1_ack, mem_en, mem_we, mem_adr, mem_wdata, busy} !== 38'd0) begin
            failures++;
            $display("FAIL abort_outputs: got %h required 0",
                     {p0_rdata, p1_rdata, p0_ack, p1_ack, mem_en, mem_we, mem_adr, mem_wdata, busy});
        end
        p0_req = 1'b0;
        bad = 0;
        repeat (3) begin @(negedge clk); if (p0_ack || p1_ack || busy) bad++; end
        reset = 1'b1;
        exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
        repeat (3) begin @(negedge clk); if (p0_ack || p1_ack || busy) bad++; end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL abort_no_ack: got %0d active cycles required 0", bad); end
        a = 8'($urandom);
        run_access(0, 1'b0, a, 8'h00, 1'b0, lat, en_cnt, we_cnt, sa, sw, oth, r0, r1);
        exp_rd[0] = ref_mem[a];
        checks++;
        if (lat != LAT || r0 !== exp_rd[0] || r1 !== 8'h00) begin
            failures++;
            $display("FAIL abort_recover: got lat=%0d rd0=%h rd1=%h required %0d/%h/00", lat, r0, r1, LAT, exp_rd[0]);
        end
    endtask

    task automatic test_zero_wait();
        int acks[$];
        int bad_busy = 0;
        int bad_gap  = 0;
        logic prev_ack = 1'b0;
        logic started  = 1'b0;
        z_adr = 8'($urandom);
        z_req = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (started && (z_busy !== !prev_ack)) bad_busy++;
            if (z_p0_ack) begin acks.push_back(c); started = 1'b1; end
            prev_ack = z_p0_ack;
        end
        z_req = 1'b0;
        @(negedge clk);
        for (int i = 1; i < acks.size(); i++) if (acks[i] - acks[i-1] != 3) bad_gap++;
        checks++;
        if (acks.size() != 7 || acks[0] != 2) begin
            failures++;
            $display("FAIL zero_wait_acks: got %0d acks first=%0d required 7 first=2",
                     acks.size(), (acks.size() > 0) ? acks[0] : -1);
        end
        checks++;
        if (bad_gap != 0) begin failures++; $display("FAIL zero_wait_period: got %0d bad gaps required 0", bad_gap); end
        checks++;
        if (bad_busy != 0) begin failures++; $display("FAIL zero_wait_busy: got %0d bad cycles required 0", bad_busy); end
        checks++;
        if (z_p0_rdata !== init_val(z_adr)) begin
            failures++; $display("FAIL zero_wait_data: got %h required %h", z_p0_rdata, init_val(z_adr));
        end
        checks++;
        if ({z_p1_ack, z_p1_rdata, z_mem_we, z_mem_wdata} !== 18'd0) begin
            failures++;
            $display("FAIL zero_wait_idle_port: got %h required 0", {z_p1_ack, z_p1_rdata, z_mem_we, z_mem_wdata});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
        exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
        reset = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_adr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_adr = '0; p1_wdata = '0;
        z_req = 1'b0; z_zero1 = 1'b0; z_adr = '0; z_zero8 = '0;
        test_reset();
        test_contention();
        test_read();
        test_write();
        test_early_drop();
        test_random();
        test_abort();
        test_zero_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter ADRBITS, default 8, address width in bits.
REQ-003 SHALL have parameter WAIT, default 1, memory wait states per access, legal range 0..7.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports pN_req  input  1  access request from requester N (N=0 fetch, N=1 data).
REQ-007 SHALL have ports pN_we  input  1  write (1) or read (0) for requester N.
REQ-008 SHALL have ports pN_adr  input  ADRBITS  address for requester N.
REQ-009 SHALL have ports pN_wdata  input  WIDTH  write data for requester N.
REQ-010 SHALL have ports pN_rdata  output  WIDTH  registered read data for requester N.
REQ-011 SHALL have ports pN_ack  output  1  one-cycle completion pulse to requester N.
REQ-012 SHALL have port mem_en  output  1  memory enable.
REQ-013 SHALL have port mem_we  output  1  memory write strobe.
REQ-014 SHALL have port mem_adr  output  ADRBITS  memory address.
REQ-015 SHALL have port mem_wdata  output  WIDTH  memory write data.
REQ-016 SHALL have port mem_rdata  input  WIDTH  memory read data, valid one cycle after mem_en.
REQ-017 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-018 FSM SHALL have three states: IDLE, ACCESS, RESP.
REQ-019 In IDLE with any pN_req high, the FSM SHALL latch the granted port's we, adr and wdata and move to ACCESS.
REQ-020 In the first ACCESS cycle, mem_en SHALL be 1, and mem_we SHALL be 1 only for writes. Both SHALL be 0 in all other cycles.
REQ-021 ACCESS SHALL last 1+WAIT cycles, counted by a 3-bit counter, and SHALL then move to RESP.
REQ-022 In RESP, reads SHALL capture mem_rdata into pN_rdata, and pN_ack SHALL be high for exactly that cycle. The FSM SHALL then return to IDLE.
REQ-023 Latency from the req-sampling edge to ack SHALL be 2+WAIT cycles. A new grant is possible in the cycle after RESP.
REQ-024 Writes SHALL ack in the same way but leave pN_rdata unchanged.
REQ-025 pN_rdata SHALL hold its value until the next read completion for that port.
REQ-026 The requester SHALL hold req, we, adr and wdata stable until ack. If req drops early, the latched access SHALL still complete and ack.
REQ-027 If req is still high in the cycle after ack, it SHALL be treated as a new request.
REQ-028 Arbitration SHALL be round-robin. If both ports request in IDLE, the port not granted last SHALL win. A lone requester SHALL always win.
REQ-029 mem_adr and mem_wdata SHALL come from the latched request registers, never combinationally from pN inputs.
REQ-030 The ack of the non-granted port SHALL stay 0, and its request SHALL remain pending without loss.

Reset
REQ-031 While reset is low, the controller SHALL go immediately (asynchronously) to IDLE.
REQ-032 While reset is low, all outputs SHALL be 0: pN_rdata, pN_ack, mem_en, mem_we, mem_adr, mem_wdata and busy.
REQ-033 Reset SHALL set the wait counter to 0 and the round-robin pointer so that p0 wins first.
REQ-034 Reset during ACCESS or RESP SHALL abort the transaction with no ack. After release, operation SHALL start from IDLE.

Structure
REQ-035 A shared package SHALL hold the state enum (IDLE, ACCESS, RESP) and the default values of WIDTH, ADRBITS and WAIT.
REQ-036 Round-robin arbitration SHALL be a sub-module rr_arb2: inputs req[1:0] and a grant-update enable; outputs a one-hot grant[1:0] plus the last-grant register.
REQ-037 The datapath and FSM SHALL stay in mem_ctrl.

Verification (WIDTH=8, ADRBITS=8, WAIT=2 unless noted)
REQ-038 Read: memory[0x10]=0x5A, p0 reads 0x10 -> p0_ack 4 cycles after request, p0_rdata=0x5A, mem_en high exactly 1 cycle.
REQ-039 Write: p1 writes 0xC3 to 0x20 -> mem_we high 1 cycle with mem_adr=0x20, mem_wdata=0xC3, p1_ack after 4 cycles. A following p1 read of 0x20 returns 0xC3.
REQ-040 Contention: after reset, p0 and p1 request together and are held -> grants p0, p1, p0, p1; no request lost, no double ack.
REQ-041 Abort: reset driven low in the second ACCESS cycle -> all outputs 0 immediately, no ack. After release, a fresh p0 read completes normally.
REQ-042 Zero wait: WAIT=0, p0 reads held continuously -> p0_ack every 3 cycles, and busy drops only in the single IDLE cycle between accesses.
REQ-043 Early drop: p1_req deasserted one cycle after grant -> access still completes and p1_ack pulses once.
